ram_rd_stream: RTL and testbench



---
 rtl/dma_lib_pkg.sv | 4 +
 rtl/rd_out_buf.sv | 44 ++++
 rtl/ram_rd_stream.sv | 89 ++++++++
 tb/tb_ram_rd_stream.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_lib_pkg.sv
// dma_lib_pkg: shared types for the DMA read-side blocks.
package dma_lib_pkg;
    typedef enum logic [0:0] {IDLE, READ} rd_stream_state_t;
endpackage

// File: rtl/rd_out_buf.sv
// rd_out_buf: 4-entry register-based FWFT FIFO with reset-cleared storage.
module rd_out_buf #(
    parameter int W = 65
) (
    input  logic         rd_clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [2:0]   count
);
    logic [W-1:0] mem_q [4];
    logic [W-1:0] mem_d [4];
    logic [1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         do_pop;

    always_comb begin
        mem_d = mem_q;
        do_pop = pop && cnt_q != 3'd0;
        if (push) mem_d[wp_q] = din;
        wp_d = wp_q + {1'b0, push};
        rp_d = rp_q + {1'b0, do_pop};
        cnt_d = cnt_q + {2'b0, push} - {2'b0, do_pop};
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = mem_q[rp_q];
    assign count = cnt_q;
endmodule

// File: rtl/ram_rd_stream.sv
// ram_rd_stream: turns (addr, len) commands into RAM reads and a ready/valid
// word stream with a per-command last flag, absorbing the 1-cycle RAM latency.
module ram_rd_stream
    import dma_lib_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    output logic                 ram_rd_en,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]     ram_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 done
);
    rd_stream_state_t     state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   rem_q, rem_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic                 issue;
    logic [2:0]           buf_count;
    logic [WIDTH:0]       buf_dout;

    // Issuing only when buffered + in-flight words <= 2 guarantees the
    // returning word always has a free buffer slot.
    assign issue = state_q == READ && ({1'b0, buf_count} + {3'b0, inflight_q}) <= 4'd2;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        rem_d = rem_q;
        if (state_q == IDLE && cmd_valid) begin
            addr_d = cmd_addr;
            rem_d = cmd_len == '0 ? (ADDR_BITS + 1)'(DEPTH) : {1'b0, cmd_len};
            state_d = READ;
        end
        if (issue) begin
            addr_d = addr_q + ADDR_BITS'(1);
            rem_d = rem_q - (ADDR_BITS + 1)'(1);
            state_d = rem_q == (ADDR_BITS + 1)'(1) ? IDLE : READ;
        end
        inflight_d = issue;
        inflight_last_d = issue && rem_q == (ADDR_BITS + 1)'(1);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            rem_q <= '0;
            inflight_q <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            inflight_q <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    rd_out_buf #(.W(WIDTH + 1)) u_buf (
        .rd_clk (rd_clk),
        .rst    (rst),
        .push   (inflight_q),
        .pop    (out_ready),
        .din    ({ram_rd_data, inflight_last_q}),
        .dout   (buf_dout),
        .count  (buf_count)
    );

    assign cmd_ready = state_q == IDLE;
    assign ram_rd_en = issue;
    assign ram_rd_addr = addr_q;
    assign out_valid = buf_count != 3'd0;
    assign out_data = buf_dout[WIDTH:1];
    assign out_last = buf_dout[0];
    assign done = out_valid && out_ready && out_last;
endmodule

// File: tb/tb_ram_rd_stream.sv
// tb_ram_rd_stream: directed + randomized checks of ram_rd_stream against a
// queue-based expected-word model, with a behavioural RAM preloaded mem[i]=i.
module tb_ram_rd_stream;
    localparam int WIDTH = 64;
    localparam int DEPTH = 512;
    localparam int AB = 9;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AB-1:0] cmd_addr = '0;
    logic [AB-1:0] cmd_len = '0;
    logic          ram_rd_en;
    logic [AB-1:0] ram_rd_addr;
    logic [WIDTH-1:0] ram_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic          out_last;
    logic          done;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH:0]   q [$];
    logic [WIDTH:0]   w;
    logic [WIDTH-1:0] h_data;
    logic             h_last, held, hs, rnd, rdy, pend;
    logic [AB-1:0]    p_addr, p_len;
    int passed = 0, total = 0, fails = 0;
    int issued = 0, popped = 0, done_cnt = 0;
    int p0, d0, i0;

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    ram_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, then observe just after it.
    task automatic tick;
        int n;
        @(negedge rd_clk);
        cmd_valid = pend;
        cmd_addr = p_addr;
        cmd_len = p_len;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : rdy;
        #1;
        if (ram_rd_en) begin
            chk("rd_gate", 64'((issued - popped) <= 2), 1);
            issued++;
        end
        if (held) begin
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_data", out_data, h_data);
            chk("hold_last", 64'(out_last), 64'(h_last));
        end
        hs = out_valid && out_ready;
        if (hs) begin
            chk("word_avail", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
                w = q.pop_front();
                chk("data", out_data, w[WIDTH:1]);
                chk("last", 64'(out_last), 64'(w[0]));
                chk("done", 64'(done), 64'(w[0]));
            end
            popped++;
            done_cnt += int'(done);
        end else if (done) begin
            chk("done_no_hs", 64'(done), 0);
        end
        held = out_valid && !out_ready;
        h_data = out_data;
        h_last = out_last;
        if (cmd_valid && cmd_ready) begin
            n = (p_len == '0) ? DEPTH : int'(p_len);
            for (int i = 0; i < n; i++)
                q.push_back({64'((int'(p_addr) + i) % DEPTH), i == n - 1});
            pend = 1'b0;
        end
    endtask

    task automatic send(input int a, input int l);
        int k;
        pend = 1'b1;
        p_addr = AB'(a);
        p_len = AB'(l);
        for (k = 0; k < 200 && pend; k++) tick();
        if (pend) chk("cmd_accept_timeout", 64'(pend), 0);
    endtask

    task automatic drain;
        for (int k = 0; k < 5000 && (q.size() != 0 || issued != popped || pend); k++) tick();
        chk("drain_q", 64'(q.size()), 0);
        chk("drain_outstanding", 64'(issued - popped), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i);
        held = 0; rnd = 0; rdy = 1; pend = 0; p_addr = '0; p_len = '0;
        @(negedge rd_clk);
        @(negedge rd_clk);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        chk("rst_rd_en", 64'(ram_rd_en), 0);
        chk("rst_rd_addr", 64'(ram_rd_addr), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", 64'(out_last), 0);
        chk("rst_done", 64'(done), 0);

        // Latency and full-rate stream: 5,6,7.
        d0 = done_cnt;
        send(5, 3);
        tick(); tick();
        chk("lat_not_yet", 64'(out_valid), 0);
        p0 = popped;
        tick();
        chk("lat_first_valid", 64'(out_valid), 1);
        tick(); tick();
        chk("rate_3_words", 64'(popped - p0), 3);
        drain();
        chk("done_count_a", 64'(done_cnt - d0), 1);

        // Address wrap.
        send(DEPTH - 2, 4);
        drain();

        // Back-to-back commands, second accepted while first still draining.
        d0 = done_cnt;
        send(0, 2);
        send(100, 2);
        chk("b2b_overlap", 64'((issued - popped) > 0), 1);
        drain();
        chk("done_count_b2b", 64'(done_cnt - d0), 2);

        // Backpressure stall mid-command.
        rdy = 0;
        i0 = issued;
        p0 = popped;
        send(200, 8);
        for (int k = 0; k < 20; k++) tick();
        chk("stall_issues", 64'(issued - i0), 3);
        chk("stall_pops", 64'(popped - p0), 0);
        rdy = 1;
        drain();

        // Full-depth command with random backpressure.
        rnd = 1;
        d0 = done_cnt;
        send(0, 0);
        drain();
        rnd = 0;
        chk("done_count_full", 64'(done_cnt - d0), 1);

        // Reset mid-command discards everything in flight.
        send(0, 16);
        for (int k = 0; k < 6; k++) tick();
        @(negedge rd_clk);
        out_ready = 1'b0;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge rd_clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_rd_en", 64'(ram_rd_en), 0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 1);
        q.delete();
        issued = 0;
        popped = 0;
        held = 0;
        d0 = done_cnt;
        send(40, 2);
        drain();
        chk("done_count_post_rst", 64'(done_cnt - d0), 1);
        tick(); tick();
        chk("post_rst_idle", 64'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
